// File: rtl/config_chain_loader.sv
// Parallel-to-serial loader for a CGRA tile configuration chain.
// It takes configuration words over valid/ready and shifts exactly CHAIN_LENGTH bits, LSB first, with a chain clock enable.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 46,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  Config_Clock,
  input  logic                  Config_Reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ConfigOut,
  output logic                  shift_en,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CHAIN_LAST_C = CNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] CHAIN_LEN_C  = CNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [CNT_WIDTH-1:0] WORD_CAP_C   =
    CNT_WIDTH'((WORD_WIDTH < CHAIN_LENGTH) ? WORD_WIDTH : CHAIN_LENGTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C        = CNT_WIDTH'(1);

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] shreg;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [CNT_WIDTH-1:0]  word_left;
  logic [CNT_WIDTH-1:0]  bits_left;

  function automatic logic [CNT_WIDTH-1:0] min_cnt(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Bits still owed to the chain; the final word is truncated to this.
  assign bits_left = CHAIN_LEN_C - bit_cnt;

  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    shift_en   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ConfigOut  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        shift_en  = 1'b1;
        ConfigOut = shreg[0];
        if (word_left == ONE_C) begin
          state_nxt = (bit_cnt == CHAIN_LAST_C) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) bit_cnt <= '0;
        end
        S_LOAD: begin
          if (word_valid) begin
            shreg     <= word_in;
            word_left <= min_cnt(bits_left, WORD_CAP_C);
          end
        end
        S_SHIFT: begin
          shreg     <= shreg >> 1;
          bit_cnt   <= bit_cnt + ONE_C;
          word_left <= word_left - ONE_C;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: table-driven and random loads checked against a stream model,
// plus reset, start-at-done, loopback and short/exact-multiple chain lengths.
module tb_config_chain_loader;

  logic        Config_Clock;
  logic        Config_Reset;
  logic        start, word_valid;
  logic [31:0] word_in;
  logic        word_ready, ConfigOut, shift_en, busy, done;

  logic        start_s, valid_s, ready_s, cfg_s, sen_s, busy_s, done_s;
  logic [31:0] word_in_s;
  logic        start_m, valid_m, ready_m, cfg_m, sen_m, busy_m, done_m;
  logic [31:0] word_in_m;

  int vectors = 0;
  int miscompares = 0;

  logic [45:0] tile;
  bit          lb_on;
  logic [31:0] lb_w0, lb_w1;

  config_chain_loader dut (
    .Config_Clock(Config_Clock), .Config_Reset(Config_Reset), .start(start),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .ConfigOut(ConfigOut), .shift_en(shift_en), .busy(busy), .done(done)
  );

  config_chain_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(20)) dut_s (
    .Config_Clock(Config_Clock), .Config_Reset(Config_Reset), .start(start_s),
    .word_in(word_in_s), .word_valid(valid_s), .word_ready(ready_s),
    .ConfigOut(cfg_s), .shift_en(sen_s), .busy(busy_s), .done(done_s)
  );

  config_chain_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(64)) dut_m (
    .Config_Clock(Config_Clock), .Config_Reset(Config_Reset), .start(start_m),
    .word_in(word_in_m), .word_valid(valid_m), .word_ready(ready_m),
    .ConfigOut(cfg_m), .shift_en(sen_m), .busy(busy_m), .done(done_m)
  );

  initial Config_Clock = 1'b0;
  always #5 Config_Clock = ~Config_Clock;

  // One 46-cell tile behind the loader; its ConfigOut is the deepest cell.
  always_ff @(posedge Config_Clock) begin
    if (shift_en) tile <= {ConfigOut, tile[45:1]};
  end

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    int          spur;
    int          exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream order: bit i of the load is bit i of the concatenated word sequence.
  function automatic logic model_bit(input logic [31:0] a, input logic [31:0] b, input int i);
    logic [63:0] s;
    s = {b, a};
    return s[i];
  endfunction

  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int stall,
                          input int spur, input bit start_at_done,
                          output int done_cyc, output int nshift);
    logic [31:0] words [2];
    int idx, c, stall_left;
    bit hs;
    words[0] = w0; words[1] = w1;
    idx = 0; c = 0; stall_left = stall; done_cyc = -1; nshift = 0;
    while (c < 300) begin
      if (shift_en) begin
        chk("serial_bit", ConfigOut, model_bit(w0, w1, nshift));
        if (lb_on) chk("loopback_bit", tile[0], model_bit(lb_w0, lb_w1, nshift));
        nshift++;
      end else begin
        chk("cfgout_quiet", ConfigOut, 1'b0);
      end
      if (c == 0) chk("busy_at_start", busy, 1'b0);
      if (word_ready && stall_left > 0 && idx >= 1) chk("stall_no_shift", shift_en, 1'b0);
      if (done) begin
        done_cyc = c;
        chk("busy_at_done", busy, 1'b0);
      end
      start = (c == 0) || (c == spur) || (start_at_done && done);
      if (idx >= 1 && stall_left > 0 && word_ready) begin
        word_valid = 1'b0;
        stall_left--;
      end else begin
        word_valid = 1'b1;
      end
      word_in = (idx < 2) ? words[idx] : 32'hDEAD_BEEF;
      hs = word_valid && word_ready;
      @(posedge Config_Clock); #1;
      if (hs) idx++;
      c++;
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    word_valid = 1'b0;
    if (done_cyc < 0) begin
      miscompares++;
      vectors++;
      $display("FAIL load_timeout: got no done expected done within 300 cycles");
    end
  endtask

  task automatic run_small();
    logic [31:0] ws0;
    logic [31:0] wm [2];
    int c, ns, nm, ds, dm, is, im;
    bit hss, hsm;
    ws0 = 32'hC3A5_96E1;
    wm[0] = 32'h8000_0001; wm[1] = 32'h1357_9BDF;
    c = 0; ns = 0; nm = 0; ds = -1; dm = -1; is = 0; im = 0;
    while (c < 200 && (ds < 0 || dm < 0)) begin
      if (sen_s) begin chk("short_bit", cfg_s, ws0[ns]); ns++; end
      if (sen_m) begin chk("multi_bit", cfg_m, wm[nm/32][nm%32]); nm++; end
      if (done_s && ds < 0) ds = c;
      if (done_m && dm < 0) dm = c;
      start_s = (c == 0); start_m = (c == 0);
      valid_s = 1'b1; valid_m = 1'b1;
      word_in_s = (is == 0) ? ws0 : 32'hFFFF_FFFF;
      word_in_m = (im < 2) ? wm[im] : 32'hFFFF_FFFF;
      hss = valid_s && ready_s;
      hsm = valid_m && ready_m;
      @(posedge Config_Clock); #1;
      if (hss) is++;
      if (hsm) im++;
      c++;
    end
    start_s = 1'b0; start_m = 1'b0; valid_s = 1'b0; valid_m = 1'b0;
    chk("short_done_cycle", ds, 22);
    chk("short_shift_count", ns, 20);
    chk("short_words_used", is, 1);
    chk("multi_done_cycle", dm, 67);
    chk("multi_shift_count", nm, 64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int dc, ns, n;
    vecs[0] = '{32'hA5A5_0F0F, 32'h0000_1234,  0, -1, 49};
    vecs[1] = '{32'hA5A5_0F0F, 32'h0000_1234, 10, -1, 59};
    vecs[2] = '{32'hA5A5_0F0F, 32'h0000_1234,  0, 20, 49};
    vecs[3] = '{32'hA5A5_0F0F, 32'hFFFF_FFFF,  0, -1, 49};
    vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0,  3, 34, 52};

    Config_Reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_in = '0;
    start_s = 1'b0; valid_s = 1'b0; word_in_s = '0;
    start_m = 1'b0; valid_m = 1'b0; word_in_m = '0;
    lb_on = 1'b0; lb_w0 = '0; lb_w1 = '0;
    repeat (2) @(posedge Config_Clock);
    #1;
    chk("rst_word_ready", word_ready, 1'b0);
    chk("rst_cfgout", ConfigOut, 1'b0);
    chk("rst_shift_en", shift_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    Config_Reset = 1'b0;

    // A word offered while idle must not be taken.
    word_valid = 1'b1; word_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge Config_Clock); #1;
      chk("idle_no_ready", word_ready, 1'b0);
    end
    word_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i].w0, vecs[i].w1, vecs[i].stall, vecs[i].spur, 1'b0, dc, ns);
      chk($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
      chk($sformatf("vec%0d_shift_count", i), ns, 46);
    end

    // start coinciding with done is dropped.
    run_load(32'h0F0F_5A5A, 32'h0000_2AAA, 0, -1, 1'b1, dc, ns);
    chk("startdone_done_cycle", dc, 49);
    for (int i = 0; i < 3; i++) begin
      chk("startdone_idle_busy", busy, 1'b0);
      chk("startdone_idle_ready", word_ready, 1'b0);
      @(posedge Config_Clock); #1;
    end

    // Asynchronous reset partway through the first word.
    start = 1'b1; word_valid = 1'b1; word_in = 32'hFFFF_FFFF;
    @(posedge Config_Clock); #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      @(posedge Config_Clock); #1;
      if (shift_en) n++;
    end
    chk("midrst_reached_shift", n, 5);
    #2 Config_Reset = 1'b1;
    #1;
    chk("midrst_shift_en", shift_en, 1'b0);
    chk("midrst_cfgout", ConfigOut, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", word_ready, 1'b0);
    @(posedge Config_Clock); #1;
    Config_Reset = 1'b0;
    repeat (2) @(posedge Config_Clock);
    #1;
    chk("midrst_no_resume", busy, 1'b0);
    run_load(32'hA5A5_0F0F, 32'h0000_1234, 0, -1, 1'b0, dc, ns);
    chk("postrst_done_cycle", dc, 49);
    chk("postrst_shift_count", ns, 46);

    // Fill the tile, then read it back through a second all-zero load.
    run_load(32'h0000_0000, 32'h0000_3FFF, 0, -1, 1'b0, dc, ns);
    lb_w0 = 32'h0000_0000; lb_w1 = 32'h0000_3FFF; lb_on = 1'b1;
    run_load(32'h0000_0000, 32'h0000_0000, 0, -1, 1'b0, dc, ns);
    lb_on = 1'b0;
    chk("loopback_shift_count", ns, 46);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      int st, sp;
      a = $urandom; b = $urandom;
      st = $urandom_range(0, 6);
      sp = $urandom_range(1, 45);
      run_load(a, b, st, sp, 1'b0, dc, ns);
      chk($sformatf("rand%0d_done_cycle", i), dc, 46 + 2 + st + 1);
      chk($sformatf("rand%0d_shift_count", i), ns, 46);
    end

    run_small();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Drives the serial configuration chain of one or more CGRA functional-unit tiles from a parallel word stream.
- Accepts 32-bit configuration words over a valid/ready handshake and serialises them LSB-first onto the chain's ConfigIn.
- Emits a shift enable that gates the chain's clock, so chain cells only advance on real bits.
- Signals completion after exactly CHAIN_LENGTH bits. Sits between the host/RoCC config interface and the first tile's ConfigIn.

Parameters:
- WORD_WIDTH, 32, width of each configuration word accepted on word_in.
- CHAIN_LENGTH, 46, total chain bits to shift per load. Default is one tile: 4+3+3+3+1 select bits plus 32 constant bits.
- CNT_WIDTH, $clog2(CHAIN_LENGTH+1), width of the internal bit counter.

Ports:
- Config_Clock  input  1  single clock for loader and chain.
- Config_Reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless idle.
- word_in  input  WORD_WIDTH  next configuration word, in bitstream order.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  loader accepts word_in this cycle.
- ConfigOut  output  1  serial bit to the first tile's ConfigIn.
- shift_en  output  1  chain clock enable; the chain advances one bit on each Config_Clock edge where shift_en=1.
- busy  output  1  high from the cycle after an accepted start until the cycle before done.
- done  output  1  one-cycle pulse once CHAIN_LENGTH bits have been shifted.

Behaviour:
- Interface: one clock, Config_Clock. Reset is Config_Reset, asynchronous and active-high.
- Reset values (and on reset assertion mid-load): state=IDLE, shreg=0, bit_cnt=0, word_left=0. Outputs word_ready=0, ConfigOut=0, shift_en=0, busy=0, done=0. A partial load is abandoned; nothing resumes after reset.
- IDLE:
  - All outputs 0.
  - start=1 -> LOAD, bit_cnt<=0.
- LOAD:
  - busy=1, word_ready=1, shift_en=0.
  - On word_valid&word_ready: shreg<=word_in and word_left<=min(WORD_WIDTH, CHAIN_LENGTH-bit_cnt), then -> SHIFT.
  - Without word_valid, stays in LOAD indefinitely. The chain does not shift during the stall.
- SHIFT:
  - busy=1, word_ready=0, shift_en=1, ConfigOut=shreg[0] (registered, not combinational from word_in).
  - Every cycle: shreg<=shreg>>1, bit_cnt<=bit_cnt+1, word_left<=word_left-1.
  - When word_left==1: if bit_cnt+1==CHAIN_LENGTH -> DONE, else -> LOAD.
- DONE:
  - done=1 for exactly one cycle; busy=0, shift_en=0, word_ready=0.
  - Then -> IDLE.
- Outside SHIFT, ConfigOut is 0.
- Last word: only its low CHAIN_LENGTH mod WORD_WIDTH bits are shifted (all WORD_WIDTH bits if the remainder is 0). Upper bits are discarded.
- Bit order:
  - Word 0 bit 0 is the first bit shifted, so it ends deepest in the chain after the load.
  - The last shifted bit lands in the MSB-adjacent position of the first ConfigCell.
- Latency with default parameters and word_valid held high:
  - start at cycle 0.
  - LOAD cycle 1, SHIFT cycles 2-33.
  - LOAD cycle 34, SHIFT cycles 35-48.
  - done at cycle 49.
  - Total 46 shift_en cycles.
- Boundary cases:
  - start during busy or DONE is ignored.
  - start asserted in the same cycle as done is ignored.
  - word_valid outside LOAD is ignored, and no word is consumed.
  - CHAIN_LENGTH < WORD_WIDTH: a single word, partially shifted.
  - CHAIN_LENGTH an exact multiple of WORD_WIDTH: no partial word.
- bit_cnt never exceeds CHAIN_LENGTH, and the number of shift_en cycles per load equals CHAIN_LENGTH exactly.

Test Plan:
- Reset mid-stream: assert Config_Reset asynchronously during SHIFT of word 0 -> outputs immediately 0 and state IDLE. A fresh start then completes a full 46-bit load.
- Nominal load: start, word0=32'hA5A50F0F, word1=32'h00001234, valid always high.
  - ConfigOut during shift_en cycles is 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1, then 0,0,1,0,1,1,0,0,0,1,0,0,1,0.
  - done at cycle 49, 46 shift_en cycles total.
- Source stall: hold word_valid=0 for 10 cycles before word1 -> shift_en=0, word_ready=1 throughout the stall. Serial stream is identical to the nominal case; done is delayed by 10 cycles.
- Spurious start: pulse start at cycle 20 of a load -> no effect, done still at cycle 49, 46 shift bits.
- Truncation: word1=32'hFFFFFFFF -> only 14 ones shifted for word1, then done. Upper 18 bits are never driven.
- Loopback: instantiate one tile behind the loader and load word0=32'h0000_0000, word1=32'h0000_3FFF. Tile ConfigOut, observed over a second all-zero load, returns the first 46 bits in shifted order.
